// File: rtl/mul_shift_add.sv
// Sequential shift-and-add unsigned multiplier, one bit per cycle.
// Ports: clk, rst_n, start/ina/inb in; ready, done, product out.
module mul_shift_add #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   ina,
  input  logic [N-1:0]   inb,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0]   r_mcand;
  logic [2*N:0]   r_work;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_product;

  logic           w_last;
  logic [N:0]     w_add;
  logic [N:0]     w_sum;
  logic [2*N:0]   w_shift;

  assign w_last  = (r_cnt == CW'(N - 1));
  assign w_add   = r_work[0] ? {1'b0, r_mcand} : '0;
  // {carry,acc} is the upper N+1 bits of the working register
  assign w_sum   = r_work[2*N:N] + w_add;
  assign w_shift = {1'b0, w_sum, r_work[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_work    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= ina;
            r_work  <= {{(N+1){1'b0}}, inb};
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          r_work <= w_shift;
          if (w_last) r_product <= w_shift[2*N-1:0];
          else        r_cnt     <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add against a cycle-level model.
// Directed cases plus a shuffled sweep of every operand pair.
module tb_mul_shift_add;

  localparam int N = 5;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   ina;
  logic [N-1:0]   inb;
  logic           ready;
  logic           done;
  logic [2*N-1:0] product;

  int n_pass;
  int n_total;
  int n_done;
  bit chk_en;

  bit m_ready;
  bit m_done;
  int m_left;
  int m_res;
  int m_prod;

  mul_shift_add #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ina     (ina),
    .inb     (inb),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: accept on an idle edge, result appears N edges later for one cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_done  <= 1'b0;
      m_left  <= 0;
      m_res   <= 0;
      m_prod  <= 0;
    end else if (m_done) begin
      m_done  <= 1'b0;
      m_ready <= 1'b1;
    end else if (m_ready) begin
      if (start) begin
        m_ready <= 1'b0;
        m_left  <= N;
        m_res   <= int'(ina) * int'(inb);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_prod <= m_res;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", int'(ready), int'(m_ready));
      check("done", int'(done), int'(m_done));
      check("product", int'(product), m_prod);
      if (done) n_done++;
    end
  end

  task automatic do_op(input int a, input int b, input int exp_p,
                       input int prev_p, input bit poke);
    int k;
    int busy;
    int d0;
    d0    = n_done;
    start = 1'b1;
    ina   = N'(a);
    inb   = N'(b);
    @(negedge clk);
    start = 1'b0;
    k     = 1;
    busy  = 0;
    check("hold_product", int'(product), prev_p);
    while (k < 20) begin
      if (!ready) busy++;
      if (done) break;
      if (poke) begin
        start = k[0];
        ina   = N'(k * 7);
        inb   = N'(k * 3 + 1);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("latency", k, N + 1);
    check("busy_cycles", busy, N + 1);
    check("result", int'(product), exp_p);
    @(negedge clk);
    check("ready_after", int'(ready), 1);
    check("product_held", int'(product), exp_p);
    @(negedge clk);
    check("one_done", n_done - d0, 1);
  endtask

  initial begin
    int k;
    int gap;
    int d0;
    int perm[1024];
    int a;
    int b;
    int t;
    n_pass  = 0;
    n_total = 0;
    n_done  = 0;
    chk_en  = 1'b0;
    start   = 1'b0;
    ina     = '0;
    inb     = '0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_product", int'(product), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_op(31, 31, 961, 0, 1'b0);
    do_op(21, 10, 210, 961, 1'b0);
    do_op(0, 17, 0, 210, 1'b0);
    do_op(1, 31, 31, 0, 1'b1);

    start = 1'b1;
    ina   = 5'd3;
    inb   = 5'd7;
    @(negedge clk);
    ina = 5'd31;
    inb = 5'd1;
    k   = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b_first_lat", k, N + 1);
    check("b2b_p1", int'(product), 21);
    @(negedge clk);
    @(negedge clk);
    ina = 5'd16;
    inb = 5'd16;
    gap = 2;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_period1", gap, N + 2);
    check("b2b_p2", int'(product), 31);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    gap   = 2;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_period2", gap, N + 2);
    check("b2b_p3", int'(product), 256);
    @(negedge clk);

    d0    = n_done;
    start = 1'b1;
    ina   = 5'd9;
    inb   = 5'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done), 0);
    check("abort_product", int'(product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_done", n_done, d0);
    do_op(5, 6, 30, 0, 1'b0);

    for (int i = 0; i < 1024; i++) perm[i] = i;
    for (int i = 1023; i > 0; i--) begin
      int j;
      int tmp;
      j       = int'($urandom_range(i, 0));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    d0 = n_done;
    for (int i = 0; i < 1024; i++) begin
      a = perm[i] >> 5;
      b = perm[i] & 31;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      start = 1'b1;
      ina   = N'(a);
      inb   = N'(b);
      @(negedge clk);
      for (int s = 1; s < N; s++) begin
        start = 1'($urandom_range(1, 0));
        ina   = N'($urandom);
        inb   = N'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      t = 0;
      while (!ready && t < 20) begin
        if (done) check("sweep_product", int'(product), a * b);
        @(negedge clk);
        t++;
      end
      if (!ready) check("sweep_timeout", 0, 1);
    end
    @(negedge clk);
    check("sweep_done_count", n_done - d0, 1024);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_shift_add.md
MUL_SHIFT_ADD -- requirements
Module: mul_shift_add

Interface
REQ-001 Parameter: N, 5, operand width in bits; the product is 2N bits wide and feeds the companion divider's dividend input.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request; sampled only when ready=1.
REQ-005 Port: ina  input  N  multiplicand (unsigned).
REQ-006 Port: inb  input  N  multiplier (unsigned).
REQ-007 Port: ready  output  1  high when idle and able to accept start.
REQ-008 Port: done  output  1  one-cycle pulse; product is valid while done=1 and afterwards.
REQ-009 Port: product  output  2N  registered result, held until the next completion.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-011 IDLE: ready=1; on an edge with start=1 the block SHALL capture ina into the multiplicand register and inb into the low N bits of the 2N+1-bit working register {carry, acc, q}. It SHALL clear carry and acc, clear the iteration counter, and go to CALC.
REQ-012 Operands SHALL be required valid only at the accepting edge; later changes on ina/inb SHALL NOT affect the result.
REQ-013 CALC: each edge SHALL perform one iteration: if q[0]=1, {carry,acc} = acc + multiplicand (N+1-bit sum), else unchanged. The whole register SHALL then shift right by one, with carry entering the MSB.
REQ-014 Iteration count SHALL be exactly N; the counter SHALL NOT wrap. At the edge performing iteration N the FSM SHALL go to DONE and load product with the final {acc,q} (2N bits).
REQ-015 Fixed latency: if start is accepted at edge E, done SHALL be 1 in the cycle between edges E+N and E+N+1, with product valid in that cycle; no zero-operand shortcut.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 ready SHALL be 0 in CALC and DONE, and start SHALL be ignored there.
REQ-018 Arithmetic SHALL be unsigned and exact: product = ina*inb for all 2^(2N) operand pairs; the maximum (2^N-1)^2 fits in 2N bits and no overflow output exists.
REQ-019 start held high continuously SHALL give back-to-back operations, one accepted per IDLE cycle: period N+2 cycles.
REQ-020 product SHALL change only at the CALC->DONE edge; otherwise it SHALL hold its value.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for clk, force: state=IDLE, ready=1, done=0, product=0, working register, multiplicand and counter all 0.
REQ-022 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse, and product SHALL read 0.
REQ-023 After rst_n is deasserted the first edge SHALL be able to accept start.

Verification
REQ-024 N=5, ina=31, inb=31, start one cycle -> ready low for 6 cycles, done pulse exactly 5 edges after acceptance, product=961 (0x3C1).
REQ-025 ina=21, inb=10 -> product=210; then ina=0, inb=17 -> product=0 with identical latency; product holds 210 until the second done.
REQ-026 ina=1, inb=31 accepted, then start pulsed and ina/inb changed during CALC -> start ignored, product=31, exactly one done.
REQ-027 start held high, operand pairs (3,7),(31,1),(16,16) -> done pulses 7 cycles apart, products 21, 31, 256.
REQ-028 rst_n pulsed low mid-CALC (between clock edges) -> outputs reset asynchronously, no done; a new op (5,6) after release -> product=30.
REQ-029 Exhaustive random sweep of all 1024 operand pairs against a reference model -> zero mismatches.
